// File: rtl/bp_stream_byte_packer.sv
// Byte-to-word stream packer.
// Bytes from a host link are packed little-endian into stream_data_width_p-bit
// words and queued in a small FIFO that feeds a valid/ready word stream.
// A partial word that sits idle for timeout_cycles_p cycles is discarded and
// reported on the sticky error_o flag.
module bp_stream_byte_packer #(
    parameter int stream_data_width_p = 32,
    parameter int fifo_els_p          = 2,
    parameter int timeout_cycles_p    = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           byte_v_i,
    input  logic [7:0]                     byte_i,
    output logic                           byte_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [31:0]                    words_o,
    output logic                           error_o
);

    localparam int bpw    = stream_data_width_p / 8;
    localparam int idx_w  = $clog2(bpw);
    localparam int ptr_w  = $clog2(fifo_els_p);
    localparam int cnt_w  = $clog2(fifo_els_p + 1);
    localparam int idle_w = $clog2(timeout_cycles_p + 1);

    localparam logic [idx_w-1:0]  last_idx     = idx_w'(bpw - 1);
    localparam logic [ptr_w-1:0]  last_ptr     = ptr_w'(fifo_els_p - 1);
    localparam logic [cnt_w-1:0]  full_count   = cnt_w'(fifo_els_p);
    localparam logic [idle_w-1:0] timeout_cnt  = idle_w'(timeout_cycles_p);

    logic [idx_w-1:0]               byte_idx_r;
    logic [stream_data_width_p-1:0] acc_r;
    logic [idle_w-1:0]              idle_r;
    logic                           error_r;
    logic [31:0]                    words_r;

    logic [stream_data_width_p-1:0] mem_r [fifo_els_p];
    logic [ptr_w-1:0]               rd_ptr_r;
    logic [ptr_w-1:0]               wr_ptr_r;
    logic [cnt_w-1:0]               fifo_count_r;

    logic                           idx_last;
    logic                           fifo_full;
    logic                           timeout;
    logic                           accept;
    logic                           push;
    logic                           pop;
    logic [stream_data_width_p-1:0] push_word;

    // Handshake and control decode. idle_r holds the number of idle cycles
    // already elapsed; the cycle in which it equals timeout_cycles_p is the
    // discard cycle, and no byte is taken in that cycle. byte_ready_o looks
    // only at registered occupancy so stream_ready_i never reaches it.
    always_comb begin
        idx_last      = (byte_idx_r == last_idx);
        fifo_full     = (fifo_count_r == full_count);
        timeout       = (idle_r == timeout_cnt);
        byte_ready_o  = reset_n_i & ~timeout & (~idx_last | ~fifo_full);
        accept        = byte_v_i & byte_ready_o;
        push          = accept & idx_last;
        stream_v_o    = reset_n_i & (fifo_count_r != '0);
        pop           = stream_v_o & stream_ready_i;
        stream_data_o = reset_n_i ? mem_r[rd_ptr_r] : '0;
    end

    // Completed word: accumulator with the final byte merged into the top lane.
    always_comb begin
        push_word = acc_r;
        push_word[stream_data_width_p-8 +: 8] = byte_i;
    end

    // Byte lane pointer: advances per accepted byte, wraps on word completion.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            byte_idx_r <= '0;
        end else if (timeout) begin
            byte_idx_r <= '0;
        end else if (accept) begin
            byte_idx_r <= idx_last ? '0 : byte_idx_r + idx_w'(1);
        end
    end

    // Accumulator: lower lanes of the word being assembled.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            acc_r <= '0;
        end else if (timeout || push) begin
            acc_r <= '0;
        end else if (accept) begin
            acc_r[{byte_idx_r, 3'b000} +: 8] <= byte_i;
        end
    end

    // Idle counter: runs only while a partial word is pending.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            idle_r <= '0;
        end else if (accept || timeout || (byte_idx_r == '0)) begin
            idle_r <= '0;
        end else begin
            idle_r <= idle_r + idle_w'(1);
        end
    end

    // Sticky discard flag.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            error_r <= 1'b0;
        end else if (timeout) begin
            error_r <= 1'b1;
        end
    end

    // Dequeued-word counter, free-running modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            words_r <= '0;
        end else if (pop) begin
            words_r <= words_r + 32'd1;
        end
    end

    // FIFO storage, cleared on reset so stale words can never resurface.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < fifo_els_p; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= push_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == last_ptr) ? '0 : wr_ptr_r + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr) ? '0 : rd_ptr_r + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_r <= fifo_count_r + cnt_w'(1);
                2'b01:   fifo_count_r <= fifo_count_r - cnt_w'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    assign words_o = words_r;
    assign error_o = error_r;

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Directed and randomized checks for bp_stream_byte_packer (32-bit words,
// two-entry FIFO, 1024-cycle timeout).
module tb_bp_stream_byte_packer;

    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        byte_v;
    logic [7:0]  byte_d;
    logic        byte_ready;
    logic        stream_v;
    logic [31:0] stream_data;
    logic        stream_ready;
    logic [31:0] words;
    logic        error;

    int errors = 0;
    int checks = 0;

    bp_stream_byte_packer #(
        .stream_data_width_p(32),
        .fifo_els_p(2),
        .timeout_cycles_p(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .byte_v_i(byte_v),
        .byte_i(byte_d),
        .byte_ready_o(byte_ready),
        .stream_v_o(stream_v),
        .stream_data_o(stream_data),
        .stream_ready_i(stream_ready),
        .words_o(words),
        .error_o(error)
    );

    always #5 clk = ~clk;

    // A final byte must never be accepted into a full FIFO.
    always @(posedge clk) begin
        if (reset_n && byte_v && byte_ready &&
            dut.byte_idx_r == 2'd3 && dut.fifo_count_r == 2'd2) begin
            errors++;
            $display("FAIL push_into_full at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; byte_v = 1'b0; byte_d = 8'h00; stream_ready = 1'b0;
        tick(); tick();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got=%0b exp=0", byte_ready); end
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL reset_stream_v got=%0b exp=0", stream_v); end
        checks++; if (stream_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", stream_data); end
        checks++; if (words !== 32'h0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", error); end
        reset_n = 1'b1;
        #1;
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL post_reset_byte_ready got=%0b exp=1", byte_ready); end
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL post_reset_stream_v got=%0b exp=0", stream_v); end
    endtask

    task automatic test_basic_word();
        logic [7:0] b [4];
        b[0] = 8'h78; b[1] = 8'h56; b[2] = 8'h34; b[3] = 8'h12;
        stream_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_v = 1'b1; byte_d = b[i];
            checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d] got=%0b exp=1", i, byte_ready); end
            tick();
            if (i < 3) begin
                checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d] got=%0b exp=0", i, stream_v); end
            end
        end
        byte_v = 1'b0;
        checks++; if (stream_v !== 1'b1) begin errors++; $display("FAIL basic_latency got=%0b exp=1", stream_v); end
        checks++; if (stream_data !== 32'h12345678) begin errors++; $display("FAIL basic_data got=%h exp=12345678", stream_data); end
        checks++; if (words !== 32'd0) begin errors++; $display("FAIL basic_words_pre got=%0d exp=0", words); end
        tick();
        checks++; if (words !== 32'd1) begin errors++; $display("FAIL basic_words got=%0d exp=1", words); end
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL basic_drained got=%0b exp=0", stream_v); end
    endtask

    task automatic test_backpressure();
        stream_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            byte_v = 1'b1; byte_d = 8'(i + 1);
            checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d] got=%0b exp=1", i, byte_ready); end
            tick();
        end
        byte_v = 1'b1; byte_d = 8'h0C;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", byte_ready); end
        checks++; if (stream_v !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0b exp=1", stream_v); end
        checks++; if (stream_data !== 32'h04030201) begin errors++; $display("FAIL bp_word0 got=%h exp=04030201", stream_data); end
        stream_ready = 1'b1;
        #1;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_path got=%0b exp=0", byte_ready); end
        tick();
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bp_space_freed got=%0b exp=1", byte_ready); end
        checks++; if (stream_data !== 32'h08070605) begin errors++; $display("FAIL bp_word1 got=%h exp=08070605", stream_data); end
        tick();
        byte_v = 1'b0;
        checks++; if (stream_v !== 1'b1) begin errors++; $display("FAIL bp_valid2 got=%0b exp=1", stream_v); end
        checks++; if (stream_data !== 32'h0C0B0A09) begin errors++; $display("FAIL bp_word2 got=%h exp=0C0B0A09", stream_data); end
        tick();
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", stream_v); end
        checks++; if (words !== 32'd4) begin errors++; $display("FAIL bp_words got=%0d exp=4", words); end
    endtask

    task automatic test_timeout();
        stream_ready = 1'b1;
        byte_v = 1'b1; byte_d = 8'hAA; tick();
        byte_d = 8'hBB; tick();
        byte_v = 1'b0;
        repeat (TIMEOUT - 1) tick();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_early_error got=%0b exp=0", error); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL to_pre_ready got=%0b exp=1", byte_ready); end
        tick();
        byte_v = 1'b1; byte_d = 8'h55;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL to_cycle_ready got=%0b exp=0", byte_ready); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_cycle_error got=%0b exp=0", error); end
        tick();
        byte_v = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error_set got=%0b exp=1", error); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL to_after_ready got=%0b exp=1", byte_ready); end
        for (int i = 1; i <= 4; i++) begin
            byte_v = 1'b1; byte_d = 8'(i); tick();
        end
        byte_v = 1'b0;
        checks++; if (stream_v !== 1'b1) begin errors++; $display("FAIL to_valid got=%0b exp=1", stream_v); end
        checks++; if (stream_data !== 32'h04030201) begin errors++; $display("FAIL to_clean_word got=%h exp=04030201", stream_data); end
        tick();
        checks++; if (words !== 32'd5) begin errors++; $display("FAIL to_words got=%0d exp=5", words); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_sticky got=%0b exp=1", error); end
    endtask

    task automatic test_reset_mid();
        stream_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            byte_v = 1'b1; byte_d = 8'(8'h11 + i); tick();
        end
        byte_v = 1'b0;
        checks++; if (stream_data !== 32'h14131211) begin errors++; $display("FAIL rm_queued got=%h exp=14131211", stream_data); end
        reset_n = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_low got=%0b exp=0", byte_ready); end
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL rm_valid_low got=%0b exp=0", stream_v); end
        checks++; if (stream_data !== 32'h0) begin errors++; $display("FAIL rm_data_low got=%h exp=0", stream_data); end
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if (words !== 32'd0) begin errors++; $display("FAIL rm_words got=%0d exp=0", words); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rm_error got=%0b exp=0", error); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%0b exp=1", byte_ready); end
        stream_ready = 1'b1;
        repeat (3) tick();
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL rm_no_stale got=%0b exp=0", stream_v); end
        for (int i = 0; i < 4; i++) begin
            byte_v = 1'b1; byte_d = 8'(8'hA1 + i); tick();
        end
        byte_v = 1'b0;
        checks++; if (stream_data !== 32'hA4A3A2A1) begin errors++; $display("FAIL rm_first_word got=%h exp=A4A3A2A1", stream_data); end
        tick();
        checks++; if (words !== 32'd1) begin errors++; $display("FAIL rm_words_after got=%0d exp=1", words); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] cur;
        logic [31:0] prev_data;
        logic        prev_stall;
        int          k;
        int          sent;
        int          cyc;
        cur = '0; prev_data = '0; prev_stall = 1'b0; k = 0; sent = 0; cyc = 0;
        reset_n = 1'b0; byte_v = 1'b0; stream_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        while (!(sent == 10000 && exp_q.size() == 0) && cyc < 80000) begin
            byte_v = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            byte_d = 8'($urandom_range(0, 255));
            stream_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                checks++;
                if (stream_v !== 1'b1 || stream_data !== prev_data) begin
                    errors++; $display("FAIL rnd_stable got=%0b/%h exp=1/%h", stream_v, stream_data, prev_data);
                end
            end
            if (stream_v && stream_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_word got=%h exp=none", stream_data);
                end else begin
                    if (stream_data !== exp_q[0]) begin
                        errors++; $display("FAIL rnd_word got=%h exp=%h", stream_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (byte_v && byte_ready) begin
                cur[8*k +: 8] = byte_d;
                sent++;
                k++;
                if (k == 4) begin
                    exp_q.push_back(cur);
                    cur = '0;
                    k = 0;
                end
            end
            prev_stall = stream_v & ~stream_ready;
            prev_data = stream_data;
            tick();
            cyc++;
        end
        byte_v = 1'b0; stream_ready = 1'b0;
        checks++; if (cyc >= 80000) begin errors++; $display("FAIL rnd_budget got=%0d cycles exp<80000", cyc); end
        checks++; if (words !== 32'd2500) begin errors++; $display("FAIL rnd_words got=%0d exp=2500", words); end
        checks++; if (stream_v !== 1'b0) begin errors++; $display("FAIL rnd_empty got=%0b exp=0", stream_v); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rnd_error got=%0b exp=0", error); end
    endtask

    task automatic test_words_wrap();
        force dut.words_r = 32'hFFFF_FFFF;
        tick();
        release dut.words_r;
        #1;
        checks++; if (words !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=FFFFFFFF", words); end
        stream_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_v = 1'b1; byte_d = 8'(8'hC0 + i); tick();
        end
        byte_v = 1'b0;
        checks++; if (stream_data !== 32'hC3C2C1C0) begin errors++; $display("FAIL wrap_data got=%h exp=C3C2C1C0", stream_data); end
        tick();
        checks++; if (words !== 32'h0) begin errors++; $display("FAIL wrap_words got=%h exp=0", words); end
    endtask

    initial begin
        reset_n = 1'b0; byte_v = 1'b0; byte_d = 8'h00; stream_ready = 1'b0;
        test_reset();
        test_basic_word();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        test_words_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_stream_byte_packer.md
# bp_stream_byte_packer

Upstream neighbour of the NBF stream loader. It accepts a byte-wide host stream (UART/host-link receiver), packs bytes little-endian into `stream_data_width_p`-bit words, and buffers them in a small FIFO. It presents the words on a valid/ready stream that connects directly to the loader's `stream_v_i`, `stream_data_i` and `stream_ready_o`. It also discards stalled partial words and reports them.

## Interface
- `stream_data_width_p`, default 32: output word width. Must be a multiple of 8 and at least 16.
- `fifo_els_p`, default 2: output FIFO depth. Must be at least 2.
- `timeout_cycles_p`, default 1024: idle cycles allowed with a partial word before it is discarded. Must be at least 1.
- `clk_i` in, 1: single clock. All state updates on the rising edge.
- `reset_n_i` in, 1: reset. Synchronous and active-low.
- `byte_v_i` in, 1: input byte valid.
- `byte_i` in, 8: input byte.
- `byte_ready_o` out, 1: byte accepted when `byte_v_i & byte_ready_o`.
- `stream_v_o` out, 1: output word valid.
- `stream_data_o` out, `stream_data_width_p`: output word.
- `stream_ready_i` in, 1: word dequeued when `stream_v_o & stream_ready_i`.
- `words_o` out, 32: count of words dequeued.
- `error_o` out, 1: sticky; set when a partial word is discarded on timeout.

## Operation
- `bpw` = `stream_data_width_p`/8. `byte_idx_r` has width `clog2(bpw)` and selects the next byte lane.
- Accepted byte k of a word is written to bits [8k+7:8k]. The first byte of a word goes in the LSB lane.
- Each accept increments `byte_idx_r`.
- When an accept has `byte_idx_r == bpw-1`:
  - the assembled word (accumulator plus this byte) is pushed into the FIFO that same cycle;
  - `byte_idx_r` wraps to 0.
- `byte_ready_o` = `reset_n_i & ((byte_idx_r != bpw-1) | (fifo_count_r < fifo_els_p))`.
  - It uses registered FIFO occupancy only, never `stream_ready_i`. There is no combinational path from stream_ready_i to byte_ready_o.
  - A pop in the same cycle does not free space for the final byte of a word.
- FIFO behaviour:
  - `stream_v_o` = `reset_n_i & (fifo_count_r != 0)`. `stream_data_o` = head entry.
  - On simultaneous push and pop, the count is unchanged and order is preserved.
  - A push into a full FIFO is impossible by construction. The bench asserts on it.
- Timeout:
  - `idle_r` counts consecutive cycles with `byte_idx_r != 0` and no accept.
  - `idle_r` clears on any accept, and whenever `byte_idx_r == 0`.
  - When `idle_r` reaches `timeout_cycles_p`, that cycle:
    - `byte_idx_r` goes to 0 and the accumulator clears;
    - `error_o` is set;
    - `idle_r` clears.
  - A byte offered in the timeout cycle is not accepted: `byte_ready_o` = 0 that cycle.
- `words_o` increments on each dequeue. It wraps 0xFFFFFFFF -> 0.
- `error_o` clears only on reset.

## Timing
- Reset (`reset_n_i` = 0 at a clock edge):
  - `byte_idx_r`, `fifo_count_r`, FIFO pointers, `idle_r`, `words_o`, `error_o` and the accumulator go to 0. FIFO storage is cleared to 0.
  - While reset is low, `byte_ready_o` = 0 and `stream_v_o` = 0. `stream_data_o` = 0.
  - After reset: `byte_ready_o` = 1, `stream_v_o` = 0.
- Reset mid-word or mid-FIFO drops all buffered bytes and words. No output appears after release until a fresh full word arrives.
- Latency: the final byte accepted in cycle N gives `stream_v_o` = 1 in cycle N+1 (FIFO previously empty).
- Throughput: one byte per cycle sustained while the consumer drains at least 1 word per `bpw` cycles.
- Handshakes: valid must not depend on ready on either side. Outputs are held stable while `stream_v_o & ~stream_ready_i`.

## Test plan
- Bytes 0x78,0x56,0x34,0x12 on consecutive cycles with `stream_ready_i` = 1 -> `stream_data_o` = 0x12345678, `stream_v_o` in the cycle after the 4th byte, `words_o` = 1.
- `stream_ready_i` held 0 while 12 bytes are offered (`fifo_els_p` = 2):
  - two words are queued and `byte_ready_o` drops exactly at the 12th byte (idx 3, FIFO full);
  - when ready is raised, words drain in order and the 12th byte is accepted the cycle after space frees.
- Two bytes 0xAA,0xBB then idle for `timeout_cycles_p` cycles:
  - `error_o` rises at exactly cycle 1024 after the last accept;
  - then bytes 0x01..0x04 give word 0x04030201, with no 0xAA/0xBB residue.
- Reset pulsed low for 1 cycle with 3 bytes pending and 1 word queued:
  - all outputs return to reset values and `words_o` = 0;
  - the next 4 bytes form the first word.
- Random `byte_v_i`/`stream_ready_i` (50% each), 10k bytes, checked against a scoreboard model:
  - no drop, duplication or reorder;
  - `words_o` = 2500;
  - valid is stable under backpressure.
- Preload `words_o` via 0xFFFFFFFF dequeues (force/backdoor), then dequeue one more word -> `words_o` = 0.
